// File: rtl/rgb2gray_pkg.sv
// rgb2gray_pkg: shared types and luma constants for the RGB-to-gray pipeline.
package rgb2gray_pkg;

   // Luma standard selected per frame
   typedef enum logic [1:0] {
      MODE_601  = 2'd0,
      MODE_709  = 2'd1,
      MODE_AVG  = 2'd2,
      MODE_PROG = 2'd3
   } mode_e;

   // Frame tracking state on the output side
   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } frame_state_e;

   // 8-bit fractional coefficients; each triple sums to 256
   localparam int unsigned K601_R = 77;
   localparam int unsigned K601_G = 150;
   localparam int unsigned K601_B = 29;
   localparam int unsigned K709_R = 54;
   localparam int unsigned K709_G = 183;
   localparam int unsigned K709_B = 19;
   localparam int unsigned KAVG_R = 85;
   localparam int unsigned KAVG_G = 86;
   localparam int unsigned KAVG_B = 85;

endpackage

// File: rtl/gray_mac3.sv
// gray_mac3: weighted sum of three channels with rounding and saturation.
// Two register stages (products, then result), both advancing on en.
module gray_mac3
   import rgb2gray_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned COEF_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [DATA_WIDTH-1:0] red_i,
   input  logic [DATA_WIDTH-1:0] green_i,
   input  logic [DATA_WIDTH-1:0] blue_i,
   input  logic [COEF_WIDTH:0]   coef_r_i,
   input  logic [COEF_WIDTH:0]   coef_g_i,
   input  logic [COEF_WIDTH:0]   coef_b_i,
   output logic [DATA_WIDTH-1:0] gray_o
);

   localparam int unsigned PW = DATA_WIDTH + COEF_WIDTH + 1;
   localparam int unsigned SW = PW + 2;
   localparam int unsigned QW = SW - COEF_WIDTH;
   localparam logic [SW-1:0] RND = SW'(1) << (COEF_WIDTH - 1);

   logic [PW-1:0] prod_r, prod_g, prod_b;
   logic [SW-1:0] sum;
   logic [QW-1:0] quot;
   logic [DATA_WIDTH-1:0] sat;

   // S2: per-channel products
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prod_r <= '0;
         prod_g <= '0;
         prod_b <= '0;
      end else if (en) begin
         prod_r <= PW'(red_i)   * PW'(coef_r_i);
         prod_g <= PW'(green_i) * PW'(coef_g_i);
         prod_b <= PW'(blue_i)  * PW'(coef_b_i);
      end
   end

   // S3 combinational part: sum, round to nearest, drop fraction, clamp
   always_comb begin
      sum  = SW'(prod_r) + SW'(prod_g) + SW'(prod_b) + RND;
      quot = sum[SW-1:COEF_WIDTH];
      sat  = quot[DATA_WIDTH-1:0];
      if (|quot[QW-1:DATA_WIDTH]) begin
         sat = '1;
      end
   end

   // S3: result register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gray_o <= '0;
      end else if (en) begin
         gray_o <= sat;
      end
   end

endmodule

// File: rtl/rgb2gray_pipe.sv
// rgb2gray_pipe: 3-stage RGB-to-gray converter with valid/ready flow control,
// per-frame luma mode, SOF/EOF sideband and output-side frame tracking.
module rgb2gray_pipe
   import rgb2gray_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned COEF_WIDTH = 8,
   parameter int unsigned CNT_WIDTH  = 20
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] red_i,
   input  logic [DATA_WIDTH-1:0] green_i,
   input  logic [DATA_WIDTH-1:0] blue_i,
   input  logic                  valid_i,
   input  logic                  sof_i,
   input  logic                  eof_i,
   output logic                  ready_o,
   input  logic [1:0]            mode_i,
   input  logic [COEF_WIDTH:0]   coef_r_i,
   input  logic [COEF_WIDTH:0]   coef_g_i,
   input  logic [COEF_WIDTH:0]   coef_b_i,
   output logic [DATA_WIDTH-1:0] gray_o,
   output logic                  valid_o,
   output logic                  sof_o,
   output logic                  eof_o,
   input  logic                  ready_i,
   output logic [CNT_WIDTH-1:0]  pix_cnt_o,
   output logic                  frame_done_o,
   output logic                  err_o
);

   localparam int unsigned KW  = COEF_WIDTH + 1;
   localparam int unsigned KSH = COEF_WIDTH - 8;

   function automatic logic [COEF_WIDTH:0] kscale(input int unsigned k8);
      return KW'(k8 << KSH);
   endfunction

   logic adv, accept, load_mode, out_hs;
   mode_e mode_q, mode_eff;
   logic [COEF_WIDTH:0] cpr_q, cpg_q, cpb_q;
   logic [COEF_WIDTH:0] k_r, k_g, k_b;
   logic [DATA_WIDTH-1:0] r1, g1, b1;
   logic [COEF_WIDTH:0] kr1, kg1, kb1;
   logic v1, sof1, eof1, v2, sof2, eof2;
   frame_state_e state_q, state_d;
   logic err_set;

   assign adv       = ready_i | ~valid_o;
   assign ready_o   = adv;
   assign accept    = valid_i & adv;
   assign load_mode = accept & sof_i;
   assign out_hs    = valid_o & ready_i;

   // Coefficient selection; an accepted SOF beat bypasses the mode register
   // so the first pixel of a frame already uses the new mode.
   always_comb begin
      mode_eff = load_mode ? mode_e'(mode_i) : mode_q;
      k_r = '0;
      k_g = '0;
      k_b = '0;
      unique case (mode_eff)
         MODE_601: begin
            k_r = kscale(K601_R);
            k_g = kscale(K601_G);
            k_b = kscale(K601_B);
         end
         MODE_709: begin
            k_r = kscale(K709_R);
            k_g = kscale(K709_G);
            k_b = kscale(K709_B);
         end
         MODE_AVG: begin
            k_r = kscale(KAVG_R);
            k_g = kscale(KAVG_G);
            k_b = kscale(KAVG_B);
         end
         MODE_PROG: begin
            k_r = load_mode ? coef_r_i : cpr_q;
            k_g = load_mode ? coef_g_i : cpg_q;
            k_b = load_mode ? coef_b_i : cpb_q;
         end
      endcase
   end

   // Mode register: captured only on accepted SOF beats
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mode_q <= MODE_601;
         cpr_q  <= '0;
         cpg_q  <= '0;
         cpb_q  <= '0;
      end else if (load_mode) begin
         mode_q <= mode_e'(mode_i);
         cpr_q  <= coef_r_i;
         cpg_q  <= coef_g_i;
         cpb_q  <= coef_b_i;
      end
   end

   // S1 data and the valid/sideband pipe, all frozen while the output stalls
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r1 <= '0; g1 <= '0; b1 <= '0;
         kr1 <= '0; kg1 <= '0; kb1 <= '0;
         v1 <= 1'b0; sof1 <= 1'b0; eof1 <= 1'b0;
         v2 <= 1'b0; sof2 <= 1'b0; eof2 <= 1'b0;
         valid_o <= 1'b0; sof_o <= 1'b0; eof_o <= 1'b0;
      end else if (adv) begin
         r1 <= red_i; g1 <= green_i; b1 <= blue_i;
         kr1 <= k_r; kg1 <= k_g; kb1 <= k_b;
         v1 <= accept; sof1 <= sof_i & accept; eof1 <= eof_i & accept;
         v2 <= v1; sof2 <= sof1; eof2 <= eof1;
         valid_o <= v2; sof_o <= sof2; eof_o <= eof2;
      end
   end

   gray_mac3 #(
      .DATA_WIDTH(DATA_WIDTH),
      .COEF_WIDTH(COEF_WIDTH)
   ) u_mac (
      .clk      (clk),
      .rst      (rst),
      .en       (adv),
      .red_i    (r1),
      .green_i  (g1),
      .blue_i   (b1),
      .coef_r_i (kr1),
      .coef_g_i (kg1),
      .coef_b_i (kb1),
      .gray_o   (gray_o)
   );

   // Frame state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Frame next-state and protocol error detection on output handshakes
   always_comb begin
      state_d = state_q;
      err_set = 1'b0;
      if (out_hs) begin
         if (sof_o) begin
            err_set = (state_q == ST_ACTIVE);
            state_d = eof_o ? ST_IDLE : ST_ACTIVE;
         end else if (state_q == ST_ACTIVE) begin
            if (eof_o) begin
               state_d = ST_IDLE;
            end
         end else begin
            // any non-SOF beat in IDLE, eof included
            err_set = 1'b1;
         end
      end
   end

   // Pixel counter, frame-done pulse and sticky error flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pix_cnt_o    <= '0;
         frame_done_o <= 1'b0;
         err_o        <= 1'b0;
      end else begin
         frame_done_o <= out_hs & eof_o;
         err_o        <= err_o | err_set;
         if (out_hs) begin
            if (sof_o) begin
               pix_cnt_o <= CNT_WIDTH'(1);
            end else if (state_q == ST_ACTIVE && pix_cnt_o != '1) begin
               pix_cnt_o <= pix_cnt_o + CNT_WIDTH'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_rgb2gray_pipe.sv
// tb_rgb2gray_pipe: scoreboard bench for rgb2gray_pipe with a reference model.
module tb_rgb2gray_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  red_i = '0, green_i = '0, blue_i = '0;
   logic        valid_i = 1'b0, sof_i = 1'b0, eof_i = 1'b0;
   logic        ready_o;
   logic [1:0]  mode_i = '0;
   logic [8:0]  coef_r_i = '0, coef_g_i = '0, coef_b_i = '0;
   logic [7:0]  gray_o;
   logic        valid_o, sof_o, eof_o;
   logic        ready_i = 1'b1;
   logic [19:0] pix_cnt_o;
   logic        frame_done_o, err_o;

   always #5 clk = ~clk;

   rgb2gray_pipe #(
      .DATA_WIDTH(8),
      .COEF_WIDTH(8),
      .CNT_WIDTH(20)
   ) dut (
      .clk(clk), .rst(rst),
      .red_i(red_i), .green_i(green_i), .blue_i(blue_i),
      .valid_i(valid_i), .sof_i(sof_i), .eof_i(eof_i), .ready_o(ready_o),
      .mode_i(mode_i), .coef_r_i(coef_r_i), .coef_g_i(coef_g_i), .coef_b_i(coef_b_i),
      .gray_o(gray_o), .valid_o(valid_o), .sof_o(sof_o), .eof_o(eof_o),
      .ready_i(ready_i), .pix_cnt_o(pix_cnt_o), .frame_done_o(frame_done_o), .err_o(err_o)
   );

   typedef struct {
      int unsigned gray;
      logic        sof;
      logic        eof;
      int unsigned acc;
      logic        lat;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int errors = 0;
   int unsigned cyc = 0;
   int rdy_mode = 0;      // 0 always ready, 1 random, 2 stalled
   logic lat_en = 1'b1;

   // bench-side view of the frame's luma mode
   int unsigned f_mode = 0, f_cr = 0, f_cg = 0, f_cb = 0;
   int unsigned ktab[3][3] = '{'{77, 150, 29}, '{54, 183, 19}, '{85, 86, 85}};

   // reference frame tracker
   logic        m_active = 1'b0, m_err = 1'b0, m_done = 1'b0;
   int unsigned m_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       ready_i = 1'b1;
         1:       ready_i = ($urandom_range(0, 3) != 0);
         default: ready_i = 1'b0;
      endcase
   end

   task automatic chk(input string nm, input longint act, input longint want);
      checks++;
      if (act != want) begin
         errors++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, want, $time);
      end
   endtask

   function automatic int unsigned ref_gray(input int unsigned r, g, b, kr, kg, kb);
      int unsigned v;
      v = (r * kr + g * kg + b * kb + 128) / 256;
      return (v > 255) ? 255 : v;
   endfunction

   task automatic send(input int unsigned r, g, b, input logic s, e,
                       input int unsigned m, cr, cg, cb);
      int unsigned n;
      logic acc;
      exp_t x;
      int unsigned kr, kg, kb;
      red_i = r[7:0]; green_i = g[7:0]; blue_i = b[7:0];
      sof_i = s; eof_i = e; mode_i = m[1:0];
      coef_r_i = cr[8:0]; coef_g_i = cg[8:0]; coef_b_i = cb[8:0];
      valid_i = 1'b1;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = ready_o;
         @(posedge clk);
         #1;
         n++;
      end
      valid_i = 1'b0; sof_i = 1'b0; eof_i = 1'b0;
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got ready_o=0 want 1 within 200 cycles");
         return;
      end
      if (s) begin
         f_mode = m; f_cr = cr; f_cg = cg; f_cb = cb;
      end
      if (f_mode == 3) begin
         kr = f_cr; kg = f_cg; kb = f_cb;
      end else begin
         kr = ktab[f_mode][0]; kg = ktab[f_mode][1]; kb = ktab[f_mode][2];
      end
      x.gray = ref_gray(r, g, b, kr, kg, kb);
      x.sof = s;
      x.eof = e;
      x.acc = cyc;
      x.lat = lat_en;
      sb.push_back(x);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
      end
      idle(3);
   endtask

   // Monitor: registered frame outputs, then any output beat against the queue
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (!rst) begin
         sb.delete();
         m_active = 1'b0; m_err = 1'b0; m_done = 1'b0; m_cnt = 0;
      end else begin
         chk("pix_cnt", pix_cnt_o, m_cnt);
         chk("err", err_o, m_err);
         chk("frame_done", frame_done_o, m_done);
         m_done = 1'b0;
         if (valid_o && ready_i) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got gray=%0d want no beat", gray_o);
            end else begin
               e = sb.pop_front();
               chk("gray", gray_o, e.gray);
               chk("sof_o", sof_o, e.sof);
               chk("eof_o", eof_o, e.eof);
               if (e.lat) chk("latency", cyc - e.acc, 2);
               m_done = e.eof;
               if (e.sof) begin
                  if (m_active) m_err = 1'b1;
                  m_cnt = 1;
                  m_active = !e.eof;
               end else if (m_active) begin
                  if (m_cnt != 20'hFFFFF) m_cnt++;
                  if (e.eof) m_active = 1'b0;
               end else begin
                  m_err = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_gray"}, gray_o, 0);
      chk({tag, "_valid"}, valid_o, 0);
      chk({tag, "_sof"}, sof_o, 0);
      chk({tag, "_eof"}, eof_o, 0);
      chk({tag, "_cnt"}, pix_cnt_o, 0);
      chk({tag, "_done"}, frame_done_o, 0);
      chk({tag, "_err"}, err_o, 0);
      chk({tag, "_ready"}, ready_o, 1);
   endtask

   initial begin
      logic [7:0] snap_g;
      logic snap_s, snap_e;
      int unsigned len, m;

      // reset state
      idle(3);
      chk_reset_outputs("rst");
      rst = 1'b1;
      idle(2);

      // BT.601 primaries and white in one frame
      send(255, 0, 0, 1, 0, 0, 0, 0, 0);
      send(0, 255, 0, 0, 0, 0, 0, 0, 0);
      send(0, 0, 255, 0, 0, 0, 0, 0, 0);
      send(255, 255, 255, 0, 1, 0, 0, 0, 0);
      wait_drain();

      // BT.709 and average, single-pixel frames
      send(100, 100, 100, 1, 1, 1, 0, 0, 0);
      send(30, 60, 90, 1, 1, 2, 0, 0, 0);
      // programmable: saturation and zero
      send(255, 255, 255, 1, 1, 3, 200, 200, 200);
      send(255, 255, 255, 1, 1, 3, 0, 0, 0);
      wait_drain();

      // mode_i changes mid-frame are ignored until the next SOF
      send(200, 100, 50, 1, 0, 0, 0, 0, 0);
      send(200, 100, 50, 0, 0, 1, 0, 0, 0);
      send(200, 100, 50, 0, 1, 2, 0, 0, 0);
      send(10, 200, 30, 1, 0, 1, 0, 0, 0);
      send(10, 200, 30, 0, 1, 1, 0, 0, 0);
      wait_drain();

      // backpressure: ready_i low for 5 cycles mid-stream
      lat_en = 1'b0;
      fork
         begin
            for (int i = 0; i < 10; i++)
               send($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                    (i == 0), (i == 9), 0, 0, 0, 0);
         end
         begin
            repeat (5) @(posedge clk);
            @(negedge clk);
            rdy_mode = 2;
            @(negedge clk);
            snap_g = gray_o; snap_s = sof_o; snap_e = eof_o;
            chk("stall_valid", valid_o, 1);
            for (int k = 0; k < 5; k++) begin
               if (k > 0) @(negedge clk);
               chk("stall_ready_o", ready_o, 0);
               chk("stall_gray", gray_o, snap_g);
               chk("stall_sof", sof_o, snap_s);
               chk("stall_eof", eof_o, snap_e);
            end
            rdy_mode = 0;
         end
      join
      wait_drain();

      // randomized frames under random backpressure
      rdy_mode = 1;
      for (int f = 0; f < 8; f++) begin
         len = $urandom_range(1, 6);
         m = $urandom_range(0, 3);
         for (int i = 0; i < int'(len); i++)
            send($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                 (i == 0), (i == int'(len) - 1),
                 (i == 0) ? m : $urandom_range(0, 3),
                 $urandom_range(0, 511), $urandom_range(0, 511), $urandom_range(0, 511));
      end
      rdy_mode = 0;
      wait_drain();
      lat_en = 1'b1;

      // SOF on the 3rd beat of an open frame
      send(5, 5, 5, 1, 0, 0, 0, 0, 0);
      send(6, 6, 6, 0, 0, 0, 0, 0, 0);
      send(7, 7, 7, 1, 0, 0, 0, 0, 0);
      send(8, 8, 8, 0, 1, 0, 0, 0, 0);
      wait_drain();
      chk("restart_err", err_o, 1);

      // async reset while stalled with a full pipe
      lat_en = 1'b0;
      send(1, 2, 3, 1, 0, 2, 0, 0, 0);
      send(4, 5, 6, 0, 0, 2, 0, 0, 0);
      send(7, 8, 9, 0, 0, 2, 0, 0, 0);
      @(negedge clk);
      rdy_mode = 2;
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b0;
      f_mode = 0; f_cr = 0; f_cg = 0; f_cb = 0;
      #1;
      chk_reset_outputs("midrst");
      @(negedge clk);
      @(posedge clk);
      #2;
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("post_rst_valid", valid_o, 0);
         chk("post_rst_ready", ready_o, 1);
      end
      rdy_mode = 0;
      idle(2);
      lat_en = 1'b1;

      // beat without SOF after reset: flagged, still converted with BT.601
      send(40, 80, 120, 0, 0, 1, 0, 0, 0);
      wait_drain();
      chk("nosof_err", err_o, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
